onedconv_xfer_responder: RTL and testbench

ONEDCONV_XFER_RESPONDER -- requirements
Module: onedconv_xfer_responder

---
 rtl/onedconv_xfer_responder_if.sv | 28 ++
 rtl/onedconv_xfer_responder.sv | 171 +++++++++++++++++
 tb/tb_onedconv_xfer_responder.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/onedconv_xfer_responder_if.sv
// rtl/onedconv_xfer_responder_if.sv - inbound/outbound stream bundle for the transfer responder
// Purpose : groups the inbound (s_*) and outbound (m_*) stream handshakes.
// Ports   : s_tdata/s_tvalid/s_tlast/s_tready  inbound stream (responder is the sink)
//           m_tdata/m_tvalid/m_tlast/m_tready  outbound stream (responder is the source)
// Modports: slave  - responder side
//           master - environment side (drives inbound data and outbound ready)
interface onedconv_xfer_responder_if #(
    parameter int DW = 16
);
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tlast;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready;

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tvalid, m_tlast
    );

    modport master (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_tlast
    );
endinterface

// File: rtl/onedconv_xfer_responder.sv
// rtl/onedconv_xfer_responder.sv - stream <-> banked BRAM transfer engine for the 1-D conv core
// Purpose : loads weight/ifmap words from the inbound stream into banked BRAM and
//           unloads ofmap words from banked BRAM onto the outbound stream.
// Ports   : clk, rst_n                     clock, async active-low reset
//           weight/ifmap_read_req          load request pulses
//           ofmap_write_req                unload request pulse
//           xfer_len                       word count sampled at transfer start (0 -> 1)
//           write_done / read_done         completion pulses for loads / unloads
//           strm                           inbound and outbound streams
//           wr_addr/wr_data/wr_en_*        BRAM write port (one-hot bank enables)
//           rd_addr/rd_en/rd_data          ofmap BRAM read port (1-cycle read latency)
//           busy, len_err                  FSM not idle, sticky tlast/count mismatch
module onedconv_xfer_responder #(
    parameter int DW     = 16,
    parameter int BANKS  = 16,
    parameter int ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     weight_read_req,
    input  logic                     ifmap_read_req,
    input  logic                     ofmap_write_req,
    input  logic [ADDR_W+3:0]        xfer_len,
    output logic                     write_done,
    output logic                     read_done,
    onedconv_xfer_responder_if.slave strm,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DW-1:0]            wr_data,
    output logic [BANKS-1:0]         wr_en_weight,
    output logic [BANKS-1:0]         wr_en_ifmap,
    output logic [ADDR_W-1:0]        rd_addr,
    output logic [BANKS-1:0]         rd_en,
    input  logic [DW-1:0]            rd_data,
    output logic                     busy,
    output logic                     len_err
);
    localparam int CW = ADDR_W + 4;
    localparam int LB = $clog2(BANKS);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RD_ISSUE, S_RD_WAIT, S_RD_SEND, S_DONE
    } state_t;

    typedef enum logic [1:0] {T_WEIGHT, T_IFMAP, T_OFMAP} xfer_t;

    state_t        r_state;
    xfer_t         r_type;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_len;
    logic          r_pend_w;
    logic          r_pend_i;
    logic          r_pend_o;
    logic          r_len_err;
    logic          r_write_done;
    logic          r_read_done;
    logic [DW-1:0] r_m_tdata;

    logic              w_idle;
    logic              w_start_w;
    logic              w_start_i;
    logic              w_start_o;
    logic              w_last;
    logic              w_beat;
    logic [CW-1:0]     w_len_in;
    logic [BANKS-1:0]  w_bank_oh;
    logic [ADDR_W-1:0] w_addr;

    assign w_idle    = (r_state == S_IDLE);
    // Fixed priority weight > ifmap > ofmap among pending requests.
    assign w_start_w = w_idle && r_pend_w;
    assign w_start_i = w_idle && !r_pend_w && r_pend_i;
    assign w_start_o = w_idle && !r_pend_w && !r_pend_i && r_pend_o;
    assign w_last    = (r_cnt == r_len - CW'(1));
    assign w_beat    = (r_state == S_LOAD) && strm.s_tvalid;
    assign w_len_in  = (xfer_len == '0) ? CW'(1) : xfer_len;
    // Word index interleaves across banks: low bits pick the bank, the rest the address.
    assign w_bank_oh = BANKS'(1) << r_cnt[LB-1:0];
    assign w_addr    = ADDR_W'(r_cnt >> LB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_type       <= T_WEIGHT;
            r_cnt        <= '0;
            r_len        <= '0;
            r_pend_w     <= 1'b0;
            r_pend_i     <= 1'b0;
            r_pend_o     <= 1'b0;
            r_len_err    <= 1'b0;
            r_write_done <= 1'b0;
            r_read_done  <= 1'b0;
            r_m_tdata    <= '0;
        end else begin
            r_write_done <= 1'b0;
            r_read_done  <= 1'b0;

            // A request for the type currently running (or starting now) is merged away.
            r_pend_w <= (r_pend_w || (weight_read_req &&
                         !(!w_idle && r_type == T_WEIGHT))) && !w_start_w;
            r_pend_i <= (r_pend_i || (ifmap_read_req &&
                         !(!w_idle && r_type == T_IFMAP))) && !w_start_i;
            r_pend_o <= (r_pend_o || (ofmap_write_req &&
                         !(!w_idle && r_type == T_OFMAP))) && !w_start_o;

            case (r_state)
                S_IDLE: begin
                    if (w_start_w || w_start_i) begin
                        r_type  <= w_start_w ? T_WEIGHT : T_IFMAP;
                        r_state <= S_LOAD;
                        r_cnt   <= '0;
                        r_len   <= w_len_in;
                    end else if (w_start_o) begin
                        r_type  <= T_OFMAP;
                        r_state <= S_RD_ISSUE;
                        r_cnt   <= '0;
                        r_len   <= w_len_in;
                    end
                end
                S_LOAD: begin
                    if (strm.s_tvalid) begin
                        // tlast is checked but never ends the transfer; the count does.
                        if (strm.s_tlast != w_last) begin
                            r_len_err <= 1'b1;
                        end
                        if (w_last) begin
                            r_state      <= S_DONE;
                            r_write_done <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                S_RD_ISSUE: r_state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    r_m_tdata <= rd_data;
                    r_state   <= S_RD_SEND;
                end
                S_RD_SEND: begin
                    if (strm.m_tready) begin
                        if (w_last) begin
                            r_state     <= S_DONE;
                            r_read_done <= 1'b1;
                        end else begin
                            r_cnt   <= r_cnt + CW'(1);
                            r_state <= S_RD_ISSUE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign strm.s_tready = (r_state == S_LOAD);
    assign strm.m_tvalid = (r_state == S_RD_SEND);
    assign strm.m_tlast  = (r_state == S_RD_SEND) && w_last;
    assign strm.m_tdata  = r_m_tdata;

    assign wr_data      = (r_state == S_LOAD) ? strm.s_tdata : '0;
    assign wr_addr      = (r_state == S_LOAD) ? w_addr : '0;
    assign wr_en_weight = (w_beat && r_type == T_WEIGHT) ? w_bank_oh : '0;
    assign wr_en_ifmap  = (w_beat && r_type == T_IFMAP) ? w_bank_oh : '0;
    assign rd_en        = (r_state == S_RD_ISSUE) ? w_bank_oh : '0;
    assign rd_addr      = (r_state == S_RD_ISSUE) ? w_addr : '0;

    assign busy       = !w_idle;
    assign len_err    = r_len_err;
    assign write_done = r_write_done;
    assign read_done  = r_read_done;
endmodule

// File: tb/tb_onedconv_xfer_responder.sv
// tb/tb_onedconv_xfer_responder.sv - scoreboard bench for onedconv_xfer_responder
module tb_onedconv_xfer_responder;
    localparam int DW     = 16;
    localparam int BANKS  = 16;
    localparam int ADDR_W = 10;
    localparam int CW     = ADDR_W + 4;
    localparam int DEPTH  = BANKS * (1 << ADDR_W);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              weight_read_req = 1'b0;
    logic              ifmap_read_req  = 1'b0;
    logic              ofmap_write_req = 1'b0;
    logic [CW-1:0]     xfer_len = '0;
    logic              write_done, read_done;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [DW-1:0]     wr_data;
    logic [BANKS-1:0]  wr_en_weight, wr_en_ifmap, rd_en;
    logic [DW-1:0]     rd_data = '0;
    logic              busy, len_err;

    onedconv_xfer_responder_if #(.DW(DW)) strm ();

    onedconv_xfer_responder #(.DW(DW), .BANKS(BANKS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .weight_read_req(weight_read_req), .ifmap_read_req(ifmap_read_req),
        .ofmap_write_req(ofmap_write_req), .xfer_len(xfer_len),
        .write_done(write_done), .read_done(read_done), .strm(strm),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_en_weight(wr_en_weight), .wr_en_ifmap(wr_en_ifmap),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
        .busy(busy), .len_err(len_err)
    );

    typedef struct {
        int            kind;   // 0 weight, 1 ifmap
        int            bank;
        int            addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    wr_t   exp_wr[$];
    beat_t exp_rd[$];
    beat_t s_q[$];
    int    exp_done[$];        // 0 write_done, 1 read_done
    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_wr     = 0;
    int    p_valid  = 100;
    int    rdy_mode = 2;       // 0 random, 1 toggle, 2 always ready

    // Ofmap BRAM contents, indexed by linear word number: word i holds 0x100 + i.
    logic [DW-1:0] ofmem [DEPTH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int oh_idx(input logic [BANKS-1:0] v);
        for (int b = 0; b < BANKS; b++) if (v[b]) return b;
        return 0;
    endfunction

    // BRAM model: one-cycle read latency, bank selected by the one-hot enable.
    always @(posedge clk) begin
        if (rd_en != '0) rd_data <= ofmem[int'(rd_addr) * BANKS + oh_idx(rd_en)];
    end

    // Expected behaviour of a load: word i lands in bank i%BANKS at address i/BANKS.
    task automatic queue_load(input int kind, input int len, input int tlast_at);
        int    n;
        int    ta;
        beat_t b;
        wr_t   w;
        n  = (len == 0) ? 1 : len;
        ta = (tlast_at < 0) ? n - 1 : tlast_at;
        for (int i = 0; i < n; i++) begin
            b.data = DW'($urandom);
            b.last = (i == ta);
            s_q.push_back(b);
            w.kind = kind; w.bank = i % BANKS; w.addr = i / BANKS; w.data = b.data;
            exp_wr.push_back(w);
        end
        exp_done.push_back(0);
    endtask

    task automatic queue_unload(input int len);
        int    n;
        beat_t b;
        n = (len == 0) ? 1 : len;
        for (int i = 0; i < n; i++) begin
            b.data = DW'(16'h0100 + i);
            b.last = (i == n - 1);
            exp_rd.push_back(b);
        end
        exp_done.push_back(1);
    endtask

    task automatic pulse(input logic w, input logic i, input logic o);
        @(posedge clk); #1;
        weight_read_req = w; ifmap_read_req = i; ofmap_write_req = o;
        @(posedge clk); #1;
        weight_read_req = 0; ifmap_read_req = 0; ofmap_write_req = 0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        @(negedge clk);
        while (k < budget && (busy || exp_wr.size() != 0 || exp_rd.size() != 0 ||
                              exp_done.size() != 0 || s_q.size() != 0)) begin
            @(negedge clk);
            k++;
        end
        chk({name, " completes"}, k < budget, 1);
    endtask

    task automatic flush_all();
        s_q.delete(); exp_wr.delete(); exp_rd.delete(); exp_done.delete();
        strm.s_tvalid = 1'b0;
    endtask

    // Inbound stream driver: presents queued beats, holding each until accepted.
    initial begin
        logic hs;
        strm.s_tvalid = 1'b0; strm.s_tdata = '0; strm.s_tlast = 1'b0; strm.m_tready = 1'b0;
        forever begin
            @(negedge clk);
            hs = strm.s_tvalid && strm.s_tready && rst_n;
            @(posedge clk); #1;
            if (hs && s_q.size() != 0) void'(s_q.pop_front());
            if (s_q.size() != 0 && ((strm.s_tvalid && !hs) || $urandom_range(99) < p_valid)) begin
                strm.s_tvalid = 1'b1; strm.s_tdata = s_q[0].data; strm.s_tlast = s_q[0].last;
            end else begin
                strm.s_tvalid = 1'b0;
            end
            case (rdy_mode)
                0:       strm.m_tready = ($urandom_range(1) == 1);
                1:       strm.m_tready = ~strm.m_tready;
                default: strm.m_tready = 1'b1;
            endcase
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a write, beat or done.
    initial begin
        wr_t           e;
        beat_t         b;
        int            d;
        int            cyc = 0;
        int            last_wr = -10;
        int            last_rd = -10;
        logic          prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        logic [BANKS-1:0] en;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (wr_en_weight != '0 || wr_en_ifmap != '0) begin
                if (exp_wr.size() == 0) chk("unexpected write", 1, 0);
                else begin
                    e = exp_wr.pop_front();
                    chk("write target", {wr_en_ifmap != '0, wr_en_weight != '0},
                        (e.kind == 0) ? 2'b01 : 2'b10);
                    en = (e.kind == 0) ? wr_en_weight : wr_en_ifmap;
                    chk("write bank", en, 64'd1 << e.bank);
                    chk("write addr", wr_addr, e.addr);
                    chk("write data", wr_data, e.data);
                end
                last_wr = cyc;
                n_wr++;
            end
            if (rd_en != '0) chk("rd_en one-hot", $onehot(rd_en), 1);
            if (prev_stall) begin
                chk("m_tvalid held", strm.m_tvalid, 1);
                chk("m_tdata held", strm.m_tdata, prev_data);
            end
            if (strm.m_tlast && !strm.m_tvalid) chk("m_tlast without m_tvalid", 1, 0);
            if (strm.m_tvalid && strm.m_tready) begin
                if (exp_rd.size() == 0) chk("unexpected out beat", 1, 0);
                else begin
                    b = exp_rd.pop_front();
                    chk("out data", strm.m_tdata, b.data);
                    chk("out last", strm.m_tlast, b.last);
                end
                last_rd = cyc;
            end
            prev_stall = strm.m_tvalid && !strm.m_tready;
            prev_data  = strm.m_tdata;
            if (write_done || read_done) begin
                if (exp_done.size() == 0) chk("unexpected done pulse", {read_done, write_done}, 0);
                else begin
                    d = exp_done.pop_front();
                    chk("done kind", {read_done, write_done}, (d == 0) ? 2'b01 : 2'b10);
                    chk("done latency", cyc - ((d == 0) ? last_wr : last_rd), 1);
                end
            end
            if (!busy) chk("idle outputs quiet",
                           {strm.s_tready, strm.m_tvalid, strm.m_tlast,
                            |wr_en_weight, |wr_en_ifmap, |rd_en}, 0);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int k;
        int base;
        int kind;
        int len;
        for (int i = 0; i < DEPTH; i++) ofmem[i] = DW'(16'h0100 + i);

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset outputs", {strm.s_tready, strm.m_tvalid, strm.m_tlast, write_done,
                              read_done, len_err}, 0);
        chk("reset enables", {wr_en_weight, wr_en_ifmap, rd_en}, 0);
        chk("reset m_tdata", strm.m_tdata, 0);
        rst_n = 1'b1;

        // Weight load of 20 words, continuous valid; word 19 -> bank 3, address 1.
        xfer_len = CW'(20); p_valid = 100; rdy_mode = 2;
        queue_load(0, 20, -1);
        pulse(1, 0, 0);
        wait_idle("weight load 20", 200);
        chk("len_err after clean load", len_err, 0);

        // Ofmap unload of 3 words with toggling ready.
        xfer_len = CW'(3); rdy_mode = 1;
        queue_unload(3);
        pulse(0, 0, 1);
        wait_idle("ofmap unload 3", 100);

        // Ifmap load of 4 words with tlast on beat 1.
        xfer_len = CW'(4); rdy_mode = 0; p_valid = 60;
        queue_load(1, 4, 1);
        pulse(0, 1, 0);
        wait_idle("ifmap early tlast", 100);
        chk("len_err after early tlast", len_err, 1);

        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        chk("len_err cleared by reset", len_err, 0);

        // All three requests together: weight, ifmap, ofmap in that order.
        xfer_len = CW'(6); p_valid = 70;
        queue_load(0, 6, -1);
        queue_load(1, 6, -1);
        queue_unload(6);
        pulse(1, 1, 1);
        wait_idle("three requests", 400);

        // Duplicate weight request during its own transfer is merged.
        xfer_len = CW'(8); p_valid = 100;
        queue_load(0, 8, -1);
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        wait_idle("merged weight request", 100);

        // Ofmap request during an active load is served after it; xfer_len re-sampled.
        xfer_len = CW'(12); p_valid = 70;
        queue_load(1, 12, -1);
        pulse(0, 1, 0);
        k = 0;
        while (!busy && k < 20) begin @(negedge clk); k++; end
        chk("load started", busy, 1);
        xfer_len = CW'(5);
        queue_unload(5);
        pulse(0, 0, 1);
        wait_idle("ofmap during load", 300);

        // Request arriving in the DONE cycle is honoured.
        xfer_len = CW'(3); p_valid = 100;
        queue_load(0, 3, -1);
        queue_load(1, 3, -1);
        pulse(1, 0, 0);
        k = 0;
        while (!write_done && k < 50) begin @(negedge clk); k++; end
        chk("first done seen", write_done, 1);
        ifmap_read_req = 1'b1;
        @(posedge clk); #1 ifmap_read_req = 1'b0;
        wait_idle("request in DONE cycle", 100);

        // Zero length behaves as one word.
        xfer_len = '0;
        queue_load(0, 0, -1);
        pulse(1, 0, 0);
        wait_idle("zero length load", 50);

        // Reset mid-load at cnt=7: everything clears, nothing resumes.
        xfer_len = CW'(20); p_valid = 100;
        base = n_wr;
        queue_load(0, 20, -1);
        pulse(1, 0, 0);
        k = 0;
        while (n_wr < base + 7 && k < 100) begin @(posedge clk); k++; end
        #2;
        chk("write active before reset", |wr_en_weight, 1);
        rst_n = 1'b0;
        #1;
        chk("async reset busy", busy, 0);
        chk("async reset stream", {strm.s_tready, strm.m_tvalid, strm.m_tlast}, 0);
        chk("async reset write port", {wr_en_weight, wr_en_ifmap, wr_addr, wr_data}, 0);
        chk("async reset done/err", {write_done, read_done, len_err}, 0);
        flush_all();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("idle after reset", busy, 0);
        chk("no writes after reset", n_wr, base + 7);

        // Randomised single transfers.
        for (int t = 0; t < 12; t++) begin
            kind = $urandom_range(2);
            len = $urandom_range(0, 40);
            p_valid = $urandom_range(40, 100);
            rdy_mode = 0;
            xfer_len = CW'(len);
            if (kind == 2) queue_unload(len);
            else queue_load(kind, len, -1);
            pulse(kind == 0, kind == 1, kind == 2);
            wait_idle("random transfer", 400);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
